// File: rtl/cache_axi_rd_bridge.sv
// Read-side bridge from the instruction cache miss path to an AXI read master.
// One request at a time: single-beat uncached read or 4-beat line refill, returned as a 128-bit line.
module cache_axi_rd_bridge #(
  parameter logic [3:0] ARID = 4'd0
) (
  input  logic         clk_g,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  localparam logic [2:0]        TYPE_LINE  = 3'b100;
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(3);
  localparam logic [LEN_W-1:0]  LEN_LINE   = LEN_W'(3);
  localparam logic [SIZE_W-1:0] SIZE_WORD  = SIZE_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic                rd_rdy_q,    rd_rdy_d;
  logic                arvalid_q,   arvalid_d;
  logic [ADDR_W-1:0]   araddr_q,    araddr_d;
  logic [LEN_W-1:0]    arlen_q,     arlen_d;
  logic [SIZE_W-1:0]   arsize_q,    arsize_d;
  logic                rready_q,    rready_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                full_q,      full_d;
  logic [LINE_W-1:0]   ret_data_q,  ret_data_d;
  logic                ret_err_q,   ret_err_d;
  logic                ret_valid_q, ret_valid_d;

  // rid carries no information for a single-outstanding master
  logic unused_rid_c;
  assign unused_rid_c = ^rid;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rd_rdy_d    = rd_rdy_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    rready_d    = rready_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    ret_data_d  = ret_data_q;
    ret_err_d   = ret_err_q;
    ret_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d    = ST_AR;
          rd_rdy_d   = 1'b0;
          arvalid_d  = 1'b1;
          cnt_d      = '0;
          full_d     = 1'b0;
          ret_data_d = '0;
          ret_err_d  = 1'b0;
          if (rd_type == TYPE_LINE) begin
            araddr_d = {rd_addr[ADDR_W-1:4], 4'h0};
            arlen_d  = LEN_LINE;
            arsize_d = SIZE_WORD;
          end else begin
            araddr_d = rd_addr;
            arlen_d  = '0;
            arsize_d = {1'b0, rd_type[1:0]};
          end
        end
      end
      ST_AR: begin
        if (arvalid_q && arready) begin
          state_d   = ST_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_R: begin
        if (rvalid && rready_q) begin
          // Beats past the fourth slot are consumed but dropped
          if (!full_q) begin
            ret_data_d[{cnt_q, 5'd0} +: BEAT_W] = rdata;
          end
          if (cnt_q == CNT_LAST) begin
            full_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          ret_err_d = ret_err_q | (rresp != RESP_OKAY);
          if (rlast) begin
            state_d     = ST_RET;
            rready_d    = 1'b0;
            ret_valid_d = 1'b1;
          end
        end
      end
      ST_RET: begin
        state_d  = ST_IDLE;
        rd_rdy_d = 1'b1;
      end
      default: begin
        state_d  = ST_IDLE;
        rd_rdy_d = 1'b1;
      end
    endcase
  end

  // State register, synchronous active-low reset
  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rd_rdy_q    <= 1'b1;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      rready_q    <= 1'b0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      ret_data_q  <= '0;
      ret_err_q   <= 1'b0;
      ret_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_rdy_q    <= rd_rdy_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      rready_q    <= rready_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      ret_data_q  <= ret_data_d;
      ret_err_q   <= ret_err_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  assign rd_rdy    = rd_rdy_q;
  assign ret_valid = ret_valid_q;
  assign ret_data  = ret_data_q;
  assign ret_err   = ret_err_q;

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

endmodule
